// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide unit: fixed-latency busy sequencing, pending result
// capture at issue, and the stall request seen by the hazard unit.
module muldiv_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] mt_data,
    input  logic        flush,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] ph;
    logic [31:0] pl;
    logic        skip_wr;
    logic        accept;
    logic [63:0] result;

    // Sign-extend by one bit when signed so a single 33x33 product covers both forms.
    function automatic logic [63:0] mul_res(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
        logic signed [32:0] xe;
        logic signed [32:0] ye;
        logic signed [65:0] p;
        xe = {sgn & x[31], x};
        ye = {sgn & y[31], y};
        p  = xe * ye;
        return p[63:0];
    endfunction

    // Returns {remainder, quotient}; zero divisor and the signed overflow case are pinned.
    function automatic logic [63:0] div_res(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic [31:0]        q;
        logic [31:0]        r;
        sx = x;
        sy = y;
        q  = '0;
        r  = '0;
        if (y == 32'd0) begin
            q = '0;
            r = '0;
        end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else if (sgn) begin
            q = sx / sy;
            r = sx % sy;
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    assign result = op[1] ? div_res(a, b, ~op[0]) : mul_res(a, b, ~op[0]);
    assign accept = (state == IDLE) && start && !flush;
    assign busy   = (state == BUSY);
    assign stall  = md_use_D & (busy | (start & ~flush));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            ph      <= '0;
            pl      <= '0;
            skip_wr <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                ph      <= result[63:32];
                pl      <= result[31:0];
                skip_wr <= op[1] && (b == 32'd0);
                cnt     <= op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                state   <= BUSY;
            end else if (!flush && !start) begin
                if (mt_hi) hi <= mt_data;
                if (mt_lo) lo <= mt_data;
            end
        end else begin
            // Commit on the last busy edge; a zero-divisor operation leaves HI/LO alone.
            if (cnt == 4'd1) begin
                if (!skip_wr) begin
                    hi <= ph;
                    lo <= pl;
                end
                cnt   <= '0;
                state <= IDLE;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO/latency queued at issue,
// popped and compared when the unit drops busy.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] mt_data;
    logic        flush;
    logic        md_use_D;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data), .flush(flush),
        .md_use_D(md_use_D), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Issue one operation, follow it through busy, and score the popped expectation.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc, input logic use_d, input logic mt_dur);
        exp_t e;
        int   n;
        e.hi = ehi; e.lo = elo; e.cyc = ecyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; md_use_D = use_d;
        #1 chk({tag, "_stall_issue"}, 64'(stall), 64'(use_d));
        @(negedge clk);
        start = 1'b0; a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5;
        mt_hi = mt_dur; mt_data = 32'h0000_ABCD;
        n = 0;
        while (busy && n < 40) begin
            #1 chk({tag, "_stall_busy"}, 64'(stall), 64'(use_d));
            n++;
            @(negedge clk);
        end
        mt_hi = 1'b0;
        #1 chk({tag, "_stall_done"}, 64'(stall), 64'd0);
        e = sb.pop_front();
        chk({tag, "_cycles"}, 64'(n), 64'(e.cyc));
        chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
        chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
        md_use_D = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;
        logic [63:0] m;
        longint      sa;
        longint      sbv;
        int          ia;
        int          ib;

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0; flush = 1'b0; md_use_D = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        md_use_D = 1'b1; start = 1'b1;
        #1 chk("rst_stall", 64'(stall), 64'd1);
        @(negedge clk);
        reset = 1'b0; start = 1'b0; md_use_D = 1'b0;
        chk("rst_ignores_start", 64'(busy), 64'd0);

        run_op("mult",  2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b1, 1'b0);
        run_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, 1'b0, 1'b0);
        run_op("div",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1, 1'b0);
        run_op("divu",  2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0, 1'b0);

        // mthi/mtlo together, then start under flush, then mthi under flush
        @(negedge clk);
        mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h55;
        @(negedge clk);
        mt_hi = 1'b0; mt_lo = 1'b0;
        chk("mt_both_hi", 64'(hi), 64'h55);
        chk("mt_both_lo", 64'(lo), 64'h55);
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9; md_use_D = 1'b1;
        #1 chk("flush_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; md_use_D = 1'b0;
        mt_hi = 1'b1; mt_data = 32'h99;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hi", 64'(hi), 64'h55);
        @(negedge clk);
        mt_hi = 1'b0; flush = 1'b0;
        chk("flush_mt_hi", 64'(hi), 64'h55);
        chk("flush_lo", 64'(lo), 64'h55);

        mt_hi = 1'b1; mt_data = 32'h11;
        @(negedge clk);
        mt_hi = 1'b0; mt_lo = 1'b1; mt_data = 32'h22;
        @(negedge clk);
        mt_lo = 1'b0;
        chk("mthi", 64'(hi), 64'h11);
        chk("mtlo", 64'(lo), 64'h22);

        run_op("divu_zero", 2'b11, 32'd123, 32'd0, 32'h11, 32'h22, 10, 1'b0, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, 1'b0, 1'b0);
        run_op("mult_mt", 2'b00, 32'h1234, 32'h10, 32'h0, 32'h0001_2340, 5, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 2'($urandom_range(0, 3));
            if (rb == 32'd0) rb = 32'd1;
            if (ra == 32'h8000_0000) ra = 32'h8000_0001;
            sa = longint'($signed(ra));
            sbv = longint'($signed(rb));
            ia = $signed(ra);
            ib = $signed(rb);
            case (ro)
                2'b00: begin m = 64'(sa * sbv); run_op("rnd_mult", ro, ra, rb, m[63:32], m[31:0], 5, 1'b1, 1'b0); end
                2'b01: begin m = {32'd0, ra} * {32'd0, rb}; run_op("rnd_multu", ro, ra, rb, m[63:32], m[31:0], 5, 1'b0, 1'b0); end
                2'b10: run_op("rnd_div", ro, ra, rb, 32'(ia % ib), 32'(ia / ib), 10, 1'b1, 1'b0);
                default: run_op("rnd_divu", ro, ra, rb, ra % rb, ra / rb, 10, 1'b0, 1'b0);
            endcase
        end

        // Reset in the third busy cycle of a divide
        @(negedge clk);
        mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h77;
        @(negedge clk);
        mt_hi = 1'b0; mt_lo = 1'b0;
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        repeat (12) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_hi", 64'(hi), 64'd0);
        chk("post_rst_lo", 64'(lo), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  E-stage issue of mult/multu/div/divu this cycle.
REQ-006 op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu; sampled only with start.
REQ-007 a  input  32  rs operand, forwarded value; sampled only with start.
REQ-008 b  input  32  rt operand, forwarded value; sampled only with start.
REQ-009 mt_hi  input  1  E-stage mthi this cycle.
REQ-010 mt_lo  input  1  E-stage mtlo this cycle.
REQ-011 mt_data  input  32  write data for mthi/mtlo.
REQ-012 flush  input  1  exception/cancel of the E-stage instruction this cycle.
REQ-013 md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-014 busy  output  1  registered; operation in progress.
REQ-015 stall  output  1  combinational stall request to the hazard unit.
REQ-016 hi  output  32  registered HI.
REQ-017 lo  output  32  registered LO.

Function
REQ-018 States IDLE and BUSY; 4-bit down-counter cnt; busy = (state == BUSY).
REQ-019 Start accepted when state IDLE, start=1, flush=0; otherwise start is ignored.
REQ-020 On accepted start: latch 64-bit result into internal pending {ph,pl}, load cnt with MULT_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1), go BUSY at that edge.
REQ-021 mult: {ph,pl} = signed a*b, 64-bit; multu: unsigned a*b, 64-bit.
REQ-022 div: pl = signed quotient truncated toward zero, ph = remainder with sign of a; divu: unsigned quotient/remainder.
REQ-023 Division with b == 0: full DIV_CYCLES busy, HI/LO left unchanged at completion.
REQ-024 Signed div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-025 In BUSY each edge decrements cnt; at the edge where cnt == 1, hi<=ph, lo<=pl, cnt<=0, state<=IDLE.
REQ-026 Latency: start accepted at edge E0 -> busy high exactly N cycles after E0; new hi/lo visible in the cycle busy first reads 0.
REQ-027 mthi/mtlo: when IDLE, flush=0, start=0: mt_hi writes hi, mt_lo writes lo, at next edge; both may assert together.
REQ-028 mt_hi/mt_lo while BUSY, with flush=1, or with start=1 in the same cycle: ignored.
REQ-029 flush never cancels an operation already in BUSY; it only suppresses start/mt_hi/mt_lo in its own cycle.
REQ-030 stall = md_use_D & (busy | (start & ~flush)).
REQ-031 stall does not depend on hi/lo values, op, or operands.
REQ-032 No output changes other than at rising edges, except stall.

Reset
REQ-033 When reset=1 at an edge: state<=IDLE, cnt<=0, hi<=0, lo<=0, pending<=0, regardless of other inputs.
REQ-034 Reset while BUSY aborts the operation; hi/lo become 0, no later completion write occurs.
REQ-035 Outputs after reset: busy=0, hi=0, lo=0; stall=md_use_D&start&~flush.

Verification
REQ-036 mult a=0xFFFFFFFE, b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-037 div a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=2 -> lo=3, hi=1.
REQ-038 hi=0x11, lo=0x22 then divu b=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
REQ-039 md_use_D=1 during mult busy -> stall=1 every busy cycle and in the start cycle, stall=0 in first cycle busy=0; md_use_D=0 -> stall=0 throughout.
REQ-040 start with flush=1 -> busy stays 0, hi/lo unchanged; mt_hi=1, mt_data=0xABCD while BUSY -> hi not 0xABCD.
REQ-041 reset=1 in cycle 3 of a div -> next cycle busy=0, hi=lo=0, and they remain 0 for 10+ cycles with no inputs.
